// File: rtl/fp32_divider_if.sv
// Start/done handshake bundle for the iterative FP32 divider.
// The requester drives the master side and the divider implements the slave side.
interface fp32_divider_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] quotient;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  quotient
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output quotient
  );
endinterface

// File: rtl/fp32_divider.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit per clock,
// truncating rounding and flush-to-zero denormals, matching the companion FP32 multiplier.
module fp32_divider (
  input  logic          clk,
  input  logic          rst,
  fp32_divider_if.slave div_if
);

  typedef enum logic [1:0] {StIdle, StDiv, StPack, StDone} state_e;

  localparam logic [31:0] QNaN    = 32'h7FC0_0000;
  localparam logic [4:0]  LastIter = 5'd24;

  state_e      state_q;
  logic        sign_q;
  logic [7:0]  ea_q;
  logic [7:0]  eb_q;
  logic [23:0] mb_q;
  logic [24:0] rem_q;
  logic [24:0] quo_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic [31:0] quotient_q;
  logic        busy_q;
  logic        done_q;

  // Operand classification; exponent field 0 counts as zero regardless of mantissa.
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic sign_in;

  always_comb begin
    a_zero  = (div_if.A[30:23] == 8'h00);
    b_zero  = (div_if.B[30:23] == 8'h00);
    a_inf   = (div_if.A[30:23] == 8'hFF) && (div_if.A[22:0] == 23'd0);
    b_inf   = (div_if.B[30:23] == 8'hFF) && (div_if.B[22:0] == 23'd0);
    a_nan   = (div_if.A[30:23] == 8'hFF) && (div_if.A[22:0] != 23'd0);
    b_nan   = (div_if.B[30:23] == 8'hFF) && (div_if.B[22:0] != 23'd0);
    sign_in = div_if.A[31] ^ div_if.B[31];
  end

  logic        special_hit;
  logic [31:0] special_d;

  always_comb begin
    special_hit = 1'b1;
    special_d   = 32'h0000_0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_d = QNaN;
    end else if (a_inf || b_zero) begin
      special_d = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero || b_inf) begin
      special_d = {sign_in, 31'd0};
    end else begin
      special_hit = 1'b0;
    end
  end

  // Restoring step: remainder stays below 2*mB, so the shifted value always fits 25 bits.
  logic [24:0] mb_ext;
  logic        rem_ge;
  logic [24:0] rem_diff;
  logic [24:0] rem_d;

  always_comb begin
    mb_ext   = {1'b0, mb_q};
    rem_ge   = (rem_q >= mb_ext);
    rem_diff = rem_q - mb_ext;
    rem_d    = rem_ge ? (rem_diff << 1) : (rem_q << 1);
  end

  // Normalise the 25-bit quotient and range-check the biased exponent.
  logic signed [9:0] exp_d;
  logic [22:0]       mant_d;
  logic [31:0]       pack_d;

  always_comb begin
    exp_d  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
           + (quo_q[24] ? 10'sd127 : 10'sd126);
    mant_d = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    if (exp_d >= 10'sd255) begin
      pack_d = {sign_q, 8'hFF, 23'd0};
    end else if (exp_d <= 10'sd0) begin
      pack_d = {sign_q, 31'd0};
    end else begin
      pack_d = {sign_q, exp_d[7:0], mant_d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      ea_q       <= 8'h00;
      eb_q       <= 8'h00;
      mb_q       <= 24'h00_0000;
      rem_q      <= 25'h000_0000;
      quo_q      <= 25'h000_0000;
      cnt_q      <= 5'd0;
      result_q   <= 32'h0000_0000;
      quotient_q <= 32'h0000_0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (div_if.start) begin
            sign_q <= sign_in;
            ea_q   <= div_if.A[30:23];
            eb_q   <= div_if.B[30:23];
            mb_q   <= {1'b1, div_if.B[22:0]};
            rem_q  <= {2'b01, div_if.A[22:0]};
            quo_q  <= 25'h000_0000;
            cnt_q  <= 5'd0;
            if (special_hit) begin
              result_q <= special_d;
              state_q  <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[23:0], rem_ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LastIter) begin
            state_q <= StPack;
          end
        end
        StPack: begin
          result_q <= pack_d;
          state_q  <= StDone;
        end
        StDone: begin
          quotient_q <= result_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_if.busy     = busy_q;
  assign div_if.done     = done_q;
  assign div_if.quotient = quotient_q;

endmodule
